// File: rtl/pcie_tx_htile_tlp_packer.sv
// pcie_tx_htile_tlp_packer: packs a TLP with a separate 128-bit header and a
// DW-aligned payload into the H-tile AVST TX layout. The header sits in the low
// DWs of the SOP beat and the payload is shifted in behind it.
// Latency: one registered output stage, 1 cycle from input accept to tx_valid.
// Backpressure: in_ready = (!tx_valid | tx_ready) and low while a flush beat is emitted.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_*                input TLP beats (valid/ready, sop/eop, hdr, data, vf_active)
//   tx_*                H-tile formatted output beats (valid/ready, sop/eop, data, vf_active)
//   err_len             sticky input-length mismatch flag
// Optional feature: define PCIE_TX_PACK_LEN_CHECK_EN to compare the input beat
// count with the header length field. When it is undefined, err_len is tied to 0
// and in_eop alone ends the TLP body.
module pcie_tx_htile_tlp_packer #(
  parameter int AVST_DW = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [127:0]       in_hdr,
  input  logic [AVST_DW-1:0] in_data,
  input  logic               in_vf_active,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_sop,
  output logic               tx_eop,
  output logic [AVST_DW-1:0] tx_data,
  output logic               tx_vf_active,
  output logic               err_len
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BODY = 2'd1, S_FLUSH = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [10:0]        rem_q, rem_d;      // DWs still to emit, counting the next beat
  logic [3:0][31:0]   carry_q, carry_d;  // DWs waiting to lead the next output beat
  logic               h4_q, h4_d;
  logic               vf_q, vf_d;
  logic               tx_valid_q, tx_valid_d;
  logic               tx_sop_q, tx_sop_d;
  logic               tx_eop_q, tx_eop_d;
  logic               tx_vf_q, tx_vf_d;
  logic [AVST_DW-1:0] tx_data_q, tx_data_d;

  // Header decode; only meaningful on the SOP beat.
  logic        hdr_h4;
  logic [10:0] hdr_len, hdr_total;
  assign hdr_h4    = in_hdr[125];
  assign hdr_len   = !in_hdr[126] ? 11'd0 :
                     (in_hdr[105:96] == 10'd0) ? 11'd1024 : {1'b0, in_hdr[105:96]};
  assign hdr_total = hdr_len + (hdr_h4 ? 11'd4 : 11'd3);

  logic               load, in_rdy, accept, sop_beat, produce, end_in, h4_cur;
  logic [3:0]         hsel;
  logic [10:0]        cur_rem;
  logic [31:0]        dw;
  logic [2:0]         idx;
  logic [31:0]        csrc [8];
  logic [AVST_DW-1:0] beat_dat;

`ifdef PCIE_TX_PACK_LEN_CHECK_EN
  logic [7:0] hdr_nin, in_left_q, in_left_d;
  logic       err_q, err_d, exp_last;
  assign hdr_nin = (hdr_len == 11'd0) ? 8'd1 : 8'((hdr_len + 11'd7) >> 3);
`endif

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    carry_d    = carry_q;
    h4_d       = h4_q;
    vf_d       = vf_q;
    tx_valid_d = tx_valid_q;
    tx_sop_d   = tx_sop_q;
    tx_eop_d   = tx_eop_q;
    tx_vf_d    = tx_vf_q;
    tx_data_d  = tx_data_q;
    beat_dat   = '0;
    dw         = '0;
    idx        = '0;
`ifdef PCIE_TX_PACK_LEN_CHECK_EN
    in_left_d  = in_left_q;
    err_d      = err_q;
`endif

    load     = !tx_valid_q || tx_ready;
    in_rdy   = load && (state_q != S_FLUSH);
    accept   = in_valid && in_rdy;
    sop_beat = (state_q == S_IDLE);
    // A non-SOP beat arriving in IDLE is consumed and dropped.
    produce  = (accept && ((sop_beat && in_sop) || state_q == S_BODY)) ||
               (load && state_q == S_FLUSH);
    h4_cur   = sop_beat ? hdr_h4 : h4_q;
    hsel     = h4_cur ? 4'd4 : 4'd3;
    cur_rem  = sop_beat ? hdr_total : rem_q;

    // Leading DWs: the header on SOP, otherwise the carried top of the previous beat.
    for (int i = 0; i < 4; i++) csrc[i] = sop_beat ? in_hdr[127-32*i -: 32] : carry_q[i];
    for (int i = 4; i < 8; i++) csrc[i] = '0;

    for (int i = 0; i < 8; i++) begin
      idx = 3'(4'(i) - hsel);
      if (4'(i) < hsel)             dw = csrc[i];
      else if (state_q == S_FLUSH)  dw = '0;
      else                          dw = in_data[32*idx +: 32];
      if (11'(i) >= cur_rem)        dw = '0;  // past the end of the TLP
      beat_dat[32*i +: 32] = dw;
    end

`ifdef PCIE_TX_PACK_LEN_CHECK_EN
    // The body ends at the expected beat count even if in_eop is late; an early
    // in_eop ends it too and the missing DWs are zero-filled by FLUSH beats.
    exp_last = sop_beat ? (hdr_nin == 8'd1) : (in_left_q <= 8'd1);
    end_in   = in_eop || exp_last;
`else
    end_in   = in_eop;
`endif

    if (produce) begin
      rem_d = (cur_rem > 11'd8) ? cur_rem - 11'd8 : 11'd0;
      if (state_q == S_FLUSH) begin
        // Normally one beat; repeats only to zero-fill after an early in_eop.
        carry_d  = '0;
        tx_eop_d = (cur_rem <= 11'd8);
        if (cur_rem <= 11'd8) state_d = S_IDLE;
      end else begin
        for (int j = 0; j < 4; j++)
          carry_d[j] = (4'(j) < hsel) ? in_data[32*(3'(4'(j) + 4'd8 - hsel)) +: 32] : 32'h0;
        tx_eop_d = end_in && (cur_rem <= 11'd8);
        if (end_in) state_d = (cur_rem > 11'd8) ? S_FLUSH : S_IDLE;
        else        state_d = S_BODY;
        if (sop_beat) begin
          h4_d = hdr_h4;
          vf_d = in_vf_active;
        end
`ifdef PCIE_TX_PACK_LEN_CHECK_EN
        if (in_eop != exp_last) err_d = 1'b1;
        in_left_d = sop_beat ? hdr_nin - 8'd1 :
                    (in_left_q != 8'd0) ? in_left_q - 8'd1 : 8'd0;
`endif
      end
      tx_sop_d  = sop_beat;
      tx_data_d = beat_dat;
      tx_vf_d   = sop_beat ? in_vf_active : vf_q;
    end
    if (load) tx_valid_d = produce;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      carry_q    <= '0;
      h4_q       <= 1'b0;
      vf_q       <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_vf_q    <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      carry_q    <= carry_d;
      h4_q       <= h4_d;
      vf_q       <= vf_d;
      tx_valid_q <= tx_valid_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      tx_vf_q    <= tx_vf_d;
      tx_data_q  <= tx_data_d;
    end
  end

`ifdef PCIE_TX_PACK_LEN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_left_q <= '0;
      err_q     <= 1'b0;
    end else begin
      in_left_q <= in_left_d;
      err_q     <= err_d;
    end
  end
  assign err_len = err_q;
`else
  assign err_len = 1'b0;
`endif

  assign in_ready     = in_rdy;
  assign tx_valid     = tx_valid_q;
  assign tx_sop       = tx_sop_q;
  assign tx_eop       = tx_eop_q;
  assign tx_data      = tx_data_q;
  assign tx_vf_active = tx_vf_q;

endmodule

// File: tb/tb_pcie_tx_htile_tlp_packer.sv
// Testbench for pcie_tx_htile_tlp_packer: a reference model turns each TLP into
// a flat DW stream (header DWs then payload DWs), chops it into 8-DW beats and
// queues them; a monitor pops and compares every accepted output beat.
module tb_pcie_tx_htile_tlp_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, in_sop, in_eop, in_vf_active;
  logic [127:0] in_hdr;
  logic [255:0] in_data;
  logic         tx_valid, tx_ready, tx_sop, tx_eop, tx_vf_active, err_len;
  logic [255:0] tx_data;

  always #5 clk = ~clk;

  pcie_tx_htile_tlp_packer #(.AVST_DW(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
    .in_hdr(in_hdr), .in_data(in_data), .in_vf_active(in_vf_active),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_data(tx_data), .tx_vf_active(tx_vf_active), .err_len(err_len)
  );

  typedef struct packed {
    logic         sop;
    logic         eop;
    logic         vf;
    logic [255:0] data;
  } beat_t;
  typedef logic [259:0] cw_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    stall_pct = 0;

  task automatic check(input string name, input cw_t act, input cw_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: flat DW stream, chopped into zero-padded 8-DW beats.
  task automatic push_tlp(input logic [127:0] hdr, input logic vf, input logic [31:0] pl[$]);
    logic [31:0] s[$];
    beat_t       b;
    int          h;
    h = hdr[125] ? 4 : 3;
    for (int i = 0; i < h; i++) s.push_back(hdr[127-32*i -: 32]);
    foreach (pl[i]) s.push_back(pl[i]);
    for (int k = 0; k < s.size(); k += 8) begin
      b.sop  = (k == 0);
      b.eop  = (k + 8 >= s.size());
      b.vf   = vf;
      b.data = '0;
      for (int j = 0; j < 8 && k + j < s.size(); j++) b.data[32*j +: 32] = s[k+j];
      exp_q.push_back(b);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send_beat(input logic sop, input logic eop, input logic [127:0] hdr,
                           input logic [255:0] dat, input logic vf);
    int guard;
    guard = 0;
    while ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid     = 1'b1;
    in_sop       = sop;
    in_eop       = eop;
    in_hdr       = sop ? hdr : {$urandom, $urandom, $urandom, $urandom};
    in_vf_active = sop ? vf : 1'($urandom);
    in_data      = dat;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 3000) begin
        n_cmp++; n_bad++;
        $display("FAIL in_ready_timeout: in_ready still 0 after %0d cycles, expected 1", guard);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // nsend <= 0 sends the length-correct number of input beats.
  task automatic send_tlp(input logic h4, input logic has_pl, input logic [9:0] len_f,
                          input int nsend);
    logic [127:0] hdr;
    logic [255:0] dat;
    logic [31:0]  pl[$];
    logic         vf;
    int           L, nin;
    hdr          = {$urandom, $urandom, $urandom, $urandom};
    hdr[126]     = has_pl;
    hdr[125]     = h4;
    hdr[105:96]  = len_f;
    vf           = 1'($urandom);
    L   = !has_pl ? 0 : (len_f == 10'd0 ? 1024 : int'(len_f));
    nin = (L == 0) ? 1 : (L + 7) / 8;
    if (nsend <= 0) nsend = nin;
    for (int i = 0; i < L; i++) pl.push_back(i < nsend * 8 ? $urandom : 32'h0);
    push_tlp(hdr, vf, pl);
    for (int b = 0; b < nsend; b++) begin
      for (int j = 0; j < 8; j++)
        dat[32*j +: 32] = (8*b + j < L) ? pl[8*b+j] : $urandom;
      send_beat(b == 0, b == nsend - 1, hdr, dat, vf);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d beats outstanding, expected 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Downstream ready: random stalls at stall_pct percent.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = ($urandom_range(0, 99) >= stall_pct);
    end
  end

  // Monitor: compare each transferred beat and hold-stability during stalls.
  beat_t held;
  logic  stalled = 1'b0;
  always @(negedge clk) begin
    beat_t cur, e;
    cur = {tx_sop, tx_eop, tx_vf_active, tx_data};
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {tx_valid, cur}, {1'b1, held});
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat: got %h with no beat expected", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat", cw_t'(cur), cw_t'(e));
        end
      end
      stalled = tx_valid && !tx_ready;
      held    = cur;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_hdr = '0; in_data = '0;
    in_vf_active = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", cw_t'(tx_valid), cw_t'(0));
    check("rst_tx_sop", cw_t'(tx_sop), cw_t'(0));
    check("rst_tx_eop", cw_t'(tx_eop), cw_t'(0));
    check("rst_tx_vf", cw_t'(tx_vf_active), cw_t'(0));
    check("rst_tx_data", cw_t'(tx_data), cw_t'(0));
    check("rst_err_len", cw_t'(err_len), cw_t'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_tlp(1'b0, 1'b1, 10'd5, 0);                   // MWr32 L=5: single beat
    send_tlp(1'b0, 1'b1, 10'd8, 0);                   // MWr32 L=8: flush beat
    send_tlp(1'b1, 1'b0, 10'($urandom_range(1, 1023)), 0); // MRd64: header only
    send_tlp(1'b1, 1'b1, 10'd0, 0);                   // MWr64 1024 DW: 129 beats
    stall_pct = 50;
    repeat (8) send_tlp(1'b0, 1'b1, 10'd8, 0);
    repeat (40) send_tlp(1'($urandom), ($urandom_range(0, 4) != 0),
                         10'($urandom_range(0, 40)), 0);
    stall_pct = 0;
    repeat (10) send_tlp(1'($urandom), 1'b1, 10'($urandom_range(1, 24)), 0);
    drain();
`ifdef PCIE_TX_PACK_LEN_CHECK_EN
    check("err_len_clean", cw_t'(err_len), cw_t'(0));
    send_tlp(1'b0, 1'b1, 10'd16, 1);                  // L=16 with eop on the first beat
    drain();
    check("err_len_set", cw_t'(err_len), cw_t'(1));
`else
    check("err_len_tied", cw_t'(err_len), cw_t'(0));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
